// File: rtl/retry_pkg.sv
// Shared definitions for the retry DMR stage: lane entry typedef macro,
// default widths and a pointer-wrap helper for non-power-of-two depths.

// Declares a packed lane entry {id, data} for a given id type and payload type.
`ifndef RETRY_TYPEDEF_LANE_ENTRY
`define RETRY_TYPEDEF_LANE_ENTRY(name_t, id_t, data_t) \
    typedef struct packed {                            \
        id_t   id;                                     \
        data_t data;                                   \
    } name_t;
`endif

package retry_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 16;
    localparam int unsigned ID_SIZE_DEFAULT   = 2;
    localparam int unsigned DEPTH_DEFAULT     = 2;

    // Circular increment that wraps from depth-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dmr_fifo_lane.sv
// Single lane of the DMR buffer: a Depth-entry circular FIFO with its own
// pointers and occupancy counter. The head entry is presented combinationally
// so a freshly written beat becomes visible the cycle after the push.

module dmr_fifo_lane
    import retry_pkg::*;
#(
    parameter int unsigned Depth   = DEPTH_DEFAULT,
    parameter type         entry_t = logic [9:0]
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t wdata_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW     = $clog2(Depth + 1);

    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntW-1:0]     count_q;
    entry_t              mem_q [Depth];

    logic push_ok;
    logic pop_ok;

    // Internal guards keep the lane consistent even if a caller misbehaves.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; cleared asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= PtrWidth'(wrap_inc(32'(wr_ptr_q), Depth));
            end
            if (pop_ok) begin
                rd_ptr_q <= PtrWidth'(wrap_inc(32'(rd_ptr_q), Depth));
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/retry_dmr_stage.sv
// Protected elastic buffer between retry_start and retry_end. Every beat is
// stored in two independent lanes; the heads are compared on output and any
// disagreement raises needs_retry_o. Lane B can be corrupted on push through
// fault_mask_i to provoke mismatches on demand.

`ifndef RETRY_TYPEDEF_LANE_ENTRY
// Fallback definition when this file is compiled on its own.
`define RETRY_TYPEDEF_LANE_ENTRY(name_t, id_t, data_t) \
    typedef struct packed {                            \
        id_t   id;                                     \
        data_t data;                                   \
    } name_t;
`endif

module retry_dmr_stage
    import retry_pkg::*;
#(
    parameter type         DataType = logic [7:0],
    parameter int unsigned IDSize   = ID_SIZE_DEFAULT,
    parameter int unsigned Depth    = DEPTH_DEFAULT,
    parameter int unsigned CntWidth = CNT_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  DataType             data_i,
    input  logic [IDSize-1:0]   id_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  DataType             fault_mask_i,
    output DataType             data_o,
    output logic [IDSize-1:0]   id_o,
    output logic                needs_retry_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [CntWidth-1:0] fault_cnt_o
);

    `RETRY_TYPEDEF_LANE_ENTRY(lane_entry_t, logic [IDSize-1:0], DataType)

    lane_entry_t wdata_a;
    lane_entry_t wdata_b;
    lane_entry_t head_a;
    lane_entry_t head_b;
    lane_entry_t head_sel;

    logic full_a;
    logic full_b;
    logic empty_a;
    logic empty_b;
    logic push;
    logic pop;

    logic [CntWidth-1:0] fault_cnt_q;

    // Upstream handshake: no bypass, a full lane blocks even during a pop.
    assign ready_o = ~full_a & ~full_b;
    assign push    = valid_i & ready_o;

    // Downstream handshake: either non-empty lane presents a beat.
    assign valid_o = ~empty_a | ~empty_b;
    assign pop     = valid_o & ready_i;

    assign wdata_a.id   = id_i;
    assign wdata_a.data = data_i;
    assign wdata_b.id   = id_i;
    assign wdata_b.data = DataType'(data_i ^ fault_mask_i);

    dmr_fifo_lane #(
        .Depth   (Depth),
        .entry_t (lane_entry_t)
    ) u_lane_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop & ~empty_a),
        .wdata_i (wdata_a),
        .rdata_o (head_a),
        .full_o  (full_a),
        .empty_o (empty_a)
    );

    dmr_fifo_lane #(
        .Depth   (Depth),
        .entry_t (lane_entry_t)
    ) u_lane_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop & ~empty_b),
        .wdata_i (wdata_b),
        .rdata_o (head_b),
        .full_o  (full_b),
        .empty_o (empty_b)
    );

    // Output mux prefers lane A; lane B only shows through if A lost its beat.
    always_comb begin
        head_sel      = empty_a ? head_b : head_a;
        data_o        = '0;
        id_o          = '0;
        needs_retry_o = 1'b0;
        if (valid_o) begin
            data_o        = head_sel.data;
            id_o          = head_sel.id;
            needs_retry_o = (empty_a != empty_b) | (head_a != head_b);
        end
    end

    // Saturating count of beats handed downstream while flagged for retry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_cnt_q <= '0;
        end else if (pop && needs_retry_o && (fault_cnt_q != '1)) begin
            fault_cnt_q <= fault_cnt_q + 1'b1;
        end
    end

    assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_retry_dmr_stage.sv
// Directed bench for retry_dmr_stage: each scenario task drives its own
// stimulus and checks hand-computed expectations at the falling edge.

module tb_retry_dmr_stage;

    logic        clk;
    logic        rst_ni;
    logic [7:0]  data_i;
    logic [1:0]  id_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  fault_mask_i;
    logic [7:0]  data_o;
    logic [1:0]  id_o;
    logic        needs_retry_o;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] fault_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    retry_dmr_stage dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .data_i        (data_i),
        .id_i          (id_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .fault_mask_i  (fault_mask_i),
        .data_o        (data_o),
        .id_o          (id_o),
        .needs_retry_o (needs_retry_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .fault_cnt_o   (fault_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: through the rising edge, stop at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({valid_o, ready_o, needs_retry_o, data_o, id_o, fault_cnt_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_hold: v=%b r=%b nr=%b d=%h id=%0d cnt=%h, want v=0 r=1 nr=0 d=00 id=0 cnt=0000",
                     valid_o, ready_o, needs_retry_o, data_o, id_o, fault_cnt_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        n_vec++;
        if ({valid_o, ready_o, needs_retry_o, data_o, fault_cnt_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_release: v=%b r=%b nr=%b d=%h cnt=%h, want v=0 r=1 nr=0 d=00 cnt=0000",
                     valid_o, ready_o, needs_retry_o, data_o, fault_cnt_o);
        end
        $display("reset: v=%b r=%b cnt=%h", valid_o, ready_o, fault_cnt_o);
    endtask

    task automatic test_basic();
        ready_i = 1'b1; valid_i = 1'b1; data_i = 8'hA5; id_i = 2'd1; fault_mask_i = 8'h00;
        step();
        n_vec++;
        if ({valid_o, data_o, id_o, needs_retry_o} !== {1'b1, 8'hA5, 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL basic_beat0: v=%b d=%h id=%0d nr=%b, want v=1 d=a5 id=1 nr=0", valid_o, data_o, id_o, needs_retry_o);
        end
        $display("basic: beat d=%h id=%0d nr=%b", data_o, id_o, needs_retry_o);
        data_i = 8'h3C; id_i = 2'd2;
        step();
        n_vec++;
        if ({valid_o, data_o, id_o, needs_retry_o} !== {1'b1, 8'h3C, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL basic_beat1: v=%b d=%h id=%0d nr=%b, want v=1 d=3c id=2 nr=0", valid_o, data_o, id_o, needs_retry_o);
        end
        $display("basic: beat d=%h id=%0d nr=%b", data_o, id_o, needs_retry_o);
        valid_i = 1'b0;
        step();
        n_vec++;
        if ({valid_o, data_o, id_o, fault_cnt_o} !== {1'b0, 8'h00, 2'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL basic_drain: v=%b d=%h id=%0d cnt=%h, want v=0 d=00 id=0 cnt=0000", valid_o, data_o, id_o, fault_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h11; id_i = 2'd0;
        step();
        n_vec++;
        if ({ready_o, valid_o, data_o} !== {1'b1, 1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL bp_first: r=%b v=%b d=%h, want r=1 v=1 d=11", ready_o, valid_o, data_o);
        end
        data_i = 8'h22; id_i = 2'd1;
        step();
        n_vec++;
        if ({ready_o, data_o, id_o} !== {1'b0, 8'h11, 2'd0}) begin
            n_err++;
            $display("FAIL bp_full: r=%b d=%h id=%0d, want r=0 d=11 id=0", ready_o, data_o, id_o);
        end
        data_i = 8'h33; id_i = 2'd2;
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if ({ready_o, valid_o, data_o, id_o} !== {1'b0, 1'b1, 8'h11, 2'd0}) begin
                n_err++;
                $display("FAIL bp_stall%0d: r=%b v=%b d=%h id=%0d, want r=0 v=1 d=11 id=0", k, ready_o, valid_o, data_o, id_o);
            end
        end
        ready_i = 1'b1;
        step();
        n_vec++;
        if ({ready_o, data_o, id_o} !== {1'b1, 8'h22, 2'd1}) begin
            n_err++;
            $display("FAIL bp_drain1: r=%b d=%h id=%0d, want r=1 d=22 id=1", ready_o, data_o, id_o);
        end
        $display("backpressure: beat d=%h id=%0d", data_o, id_o);
        step();
        valid_i = 1'b0;
        n_vec++;
        if ({valid_o, data_o, id_o} !== {1'b1, 8'h33, 2'd2}) begin
            n_err++;
            $display("FAIL bp_drain2: v=%b d=%h id=%0d, want v=1 d=33 id=2", valid_o, data_o, id_o);
        end
        $display("backpressure: beat d=%h id=%0d", data_o, id_o);
        step();
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: v=%b, want v=0", valid_o);
        end
    endtask

    task automatic test_fault_inject();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h55; id_i = 2'd3; fault_mask_i = 8'h01;
        step();
        valid_i = 1'b0; fault_mask_i = 8'h00;
        n_vec++;
        if ({valid_o, data_o, needs_retry_o, fault_cnt_o} !== {1'b1, 8'h55, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL fi_flag: v=%b d=%h nr=%b cnt=%h, want v=1 d=55 nr=1 cnt=0000", valid_o, data_o, needs_retry_o, fault_cnt_o);
        end
        $display("fault_inject: beat d=%h nr=%b", data_o, needs_retry_o);
        step();
        n_vec++;
        if ({data_o, needs_retry_o, fault_cnt_o} !== {8'h55, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL fi_hold: d=%h nr=%b cnt=%h, want d=55 nr=1 cnt=0000", data_o, needs_retry_o, fault_cnt_o);
        end
        ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h66; id_i = 2'd0;
        step();
        valid_i = 1'b0;
        n_vec++;
        if ({data_o, needs_retry_o, fault_cnt_o} !== {8'h66, 1'b0, 16'h0001}) begin
            n_err++;
            $display("FAIL fi_after: d=%h nr=%b cnt=%h, want d=66 nr=0 cnt=0001", data_o, needs_retry_o, fault_cnt_o);
        end
        $display("fault_inject: beat d=%h nr=%b cnt=%h", data_o, needs_retry_o, fault_cnt_o);
        step();
        n_vec++;
        if ({valid_o, fault_cnt_o} !== {1'b0, 16'h0001}) begin
            n_err++;
            $display("FAIL fi_empty: v=%b cnt=%h, want v=0 cnt=0001", valid_o, fault_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic [1:0] exp_id;
        ready_i = 1'b1; valid_i = 1'b1; fault_mask_i = 8'h00;
        for (int i = 0; i < 100; i++) begin
            exp_d  = 8'(i * 7 + 3);
            exp_id = 2'(i);
            data_i = exp_d;
            id_i   = exp_id;
            n_vec++;
            if (ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready%0d: r=%b, want r=1", i, ready_o);
            end
            step();
            n_vec++;
            if ({valid_o, data_o, id_o, needs_retry_o} !== {1'b1, exp_d, exp_id, 1'b0}) begin
                n_err++;
                $display("FAIL b2b_beat%0d: v=%b d=%h id=%0d nr=%b, want v=1 d=%h id=%0d nr=0",
                         i, valid_o, data_o, id_o, needs_retry_o, exp_d, exp_id);
            end
            $display("b2b: beat %0d d=%h id=%0d", i, data_o, id_o);
        end
        valid_i = 1'b0;
        step();
        n_vec++;
        if ({valid_o, fault_cnt_o} !== {1'b0, 16'h0001}) begin
            n_err++;
            $display("FAIL b2b_drain: v=%b cnt=%h, want v=0 cnt=0001", valid_o, fault_cnt_o);
        end
    endtask

    task automatic test_count_corrupt();
        ready_i = 1'b0; valid_i = 1'b0;
        force dut.u_lane_b.count_q = 2'd1;
        #1;
        n_vec++;
        if ({valid_o, needs_retry_o} !== {1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL corrupt_flag: v=%b nr=%b, want v=1 nr=1", valid_o, needs_retry_o);
        end
        $display("count_corrupt: v=%b nr=%b", valid_o, needs_retry_o);
        release dut.u_lane_b.count_q;
        #1;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        n_vec++;
        if ({valid_o, ready_o, fault_cnt_o} !== {1'b0, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL corrupt_clear: v=%b r=%b cnt=%h, want v=0 r=1 cnt=0000", valid_o, ready_o, fault_cnt_o);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] exp_cnt [4];
        exp_cnt[0] = 16'hFFFD; exp_cnt[1] = 16'hFFFE; exp_cnt[2] = 16'hFFFF; exp_cnt[3] = 16'hFFFF;
        ready_i = 1'b0; valid_i = 1'b1; fault_mask_i = 8'h00; data_i = 8'h77; id_i = 2'd1;
        step();
        data_i = 8'h88; id_i = 2'd2;
        step();
        valid_i = 1'b0;
        n_vec++;
        if ({valid_o, ready_o, data_o} !== {1'b1, 1'b0, 8'h77}) begin
            n_err++;
            $display("FAIL mid_buffered: v=%b r=%b d=%h, want v=1 r=0 d=77", valid_o, ready_o, data_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({valid_o, ready_o, data_o, fault_cnt_o} !== {1'b0, 1'b1, 8'h00, 16'h0000}) begin
            n_err++;
            $display("FAIL mid_async: v=%b r=%b d=%h cnt=%h, want v=0 r=1 d=00 cnt=0000", valid_o, ready_o, data_o, fault_cnt_o);
        end
        $display("reset_midstream: async v=%b r=%b", valid_o, ready_o);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        ready_i = 1'b1;
        step();
        n_vec++;
        if ({valid_o, ready_o, fault_cnt_o} !== {1'b0, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL mid_nostale: v=%b r=%b cnt=%h, want v=0 r=1 cnt=0000", valid_o, ready_o, fault_cnt_o);
        end
        // Preset the counter close to saturation, then push three corrupted beats.
        force dut.fault_cnt_q = 16'hFFFD;
        #1;
        release dut.fault_cnt_q;
        fault_mask_i = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            valid_i = (k < 3);
            data_i  = 8'(8'h10 + k);
            id_i    = 2'(k);
            step();
            n_vec++;
            if (fault_cnt_o !== exp_cnt[k]) begin
                n_err++;
                $display("FAIL sat_cnt%0d: cnt=%h, want %h", k, fault_cnt_o, exp_cnt[k]);
            end
            $display("saturate: step %0d nr=%b cnt=%h", k, needs_retry_o, fault_cnt_o);
        end
        valid_i = 1'b0; fault_mask_i = 8'h00;
        step();
        n_vec++;
        if ({valid_o, fault_cnt_o} !== {1'b0, 16'hFFFF}) begin
            n_err++;
            $display("FAIL sat_final: v=%b cnt=%h, want v=0 cnt=ffff", valid_o, fault_cnt_o);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        data_i = 8'h00;
        id_i = 2'd0;
        valid_i = 1'b0;
        fault_mask_i = 8'h00;
        ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_fault_inject();
        test_back_to_back();
        test_count_corrupt();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
